// File: rtl/move_link.sv
// Move exchange link: sends local moves with ACK/retry and delivers plus ACKs remote moves.
// Optional macro MOVE_LINK_DUP_FILTER_EN: a repeat of the last delivered move is ACKed silently.
module move_link #(
    parameter int unsigned TX_GAP_CYCLES = 67_710,
    parameter int unsigned ACK_TIMEOUT   = 6_500_000,
    parameter int unsigned MAX_RETRY     = 3,
    parameter logic [7:0]  ACK_BYTE      = 8'hFF
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       send_move,
    input  logic [7:0] move_in,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       tx_trigger,
    output logic [7:0] tx_data,
    output logic       move_valid,
    output logic [7:0] move_out,
    output logic       link_busy,
    output logic       link_error
);

    localparam int GAP_W = (TX_GAP_CYCLES > 1) ? $clog2(TX_GAP_CYCLES) : 1;
    localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // The gap counter is loaded with GAP-1 so the next trigger lands exactly GAP clocks later.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((TX_GAP_CYCLES > 0) ? TX_GAP_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        SEND_MOVE,
        WAIT_ACK,
        SEND_ACK,
        ERROR
    } state_t;

    state_t             state;
    logic               pending;
    logic               resend;
    logic               resume_wait;
    logic [7:0]         move_reg;
    logic [7:0]         inflight;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [RTY_W-1:0]   retry_cnt;

    logic rx_ack;
    logic rx_move;
    logic deliver;

    assign rx_ack  = rx_ready && (rx_data == ACK_BYTE);
    assign rx_move = rx_ready && (rx_data != ACK_BYTE);

`ifdef MOVE_LINK_DUP_FILTER_EN
    logic delivered;
    assign deliver = rx_move && !(delivered && (rx_data == move_out));
`else
    assign deliver = rx_move;
`endif

    assign link_busy = (state != IDLE) || pending;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            pending     <= 1'b0;
            resend      <= 1'b0;
            resume_wait <= 1'b0;
            move_reg    <= 8'h00;
            inflight    <= 8'h00;
            gap_cnt     <= '0;
            tmo_cnt     <= '0;
            retry_cnt   <= '0;
            tx_trigger  <= 1'b0;
            tx_data     <= 8'h00;
            move_valid  <= 1'b0;
            move_out    <= 8'h00;
            link_error  <= 1'b0;
`ifdef MOVE_LINK_DUP_FILTER_EN
            delivered   <= 1'b0;
`endif
        end else begin
            tx_trigger <= 1'b0;
            move_valid <= 1'b0;

            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if (send_move && (state != ERROR)) begin
                move_reg <= move_in;
                pending  <= 1'b1;
            end

            // A received move preempts everything in IDLE and WAIT_ACK; the ACK is queued first.
            if (rx_move && ((state == IDLE) || (state == WAIT_ACK))) begin
                if (deliver) begin
                    move_out   <= rx_data;
                    move_valid <= 1'b1;
`ifdef MOVE_LINK_DUP_FILTER_EN
                    delivered  <= 1'b1;
`endif
                end
                resume_wait <= (state == WAIT_ACK);
                state       <= SEND_ACK;
            end else begin
                case (state)
                    IDLE: begin
                        if (pending) begin
                            resend <= 1'b0;
                            state  <= SEND_MOVE;
                        end
                    end

                    SEND_MOVE: begin
                        if (gap_cnt == '0) begin
                            tx_trigger <= 1'b1;
                            gap_cnt    <= GAP_LOAD;
                            tmo_cnt    <= '0;
                            state      <= WAIT_ACK;
                            if (resend) begin
                                tx_data <= inflight;
                            end else begin
                                tx_data   <= move_reg;
                                inflight  <= move_reg;
                                retry_cnt <= '0;
                                if (!send_move) begin
                                    pending <= 1'b0;
                                end
                            end
                        end
                    end

                    WAIT_ACK: begin
                        if (rx_ack) begin
                            state <= IDLE;
                        end else if (gap_cnt == '0) begin
                            if (tmo_cnt == TMO_LAST) begin
                                tmo_cnt <= '0;
                                if (retry_cnt < RTY_MAX) begin
                                    retry_cnt <= retry_cnt + 1'b1;
                                    resend    <= 1'b1;
                                    state     <= SEND_MOVE;
                                end else begin
                                    link_error <= 1'b1;
                                    state      <= ERROR;
                                end
                            end else begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                            end
                        end
                    end

                    SEND_ACK: begin
                        if (gap_cnt == '0) begin
                            tx_trigger <= 1'b1;
                            tx_data    <= ACK_BYTE;
                            gap_cnt    <= GAP_LOAD;
                            tmo_cnt    <= '0;
                            state      <= resume_wait ? WAIT_ACK : IDLE;
                        end
                    end

                    ERROR: begin
                        link_error <= 1'b1;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_link.sv
// Directed self-checking bench for move_link with gap 10, timeout 50 and two retries.
`timescale 1ns/1ps
module tb_move_link;

    localparam int GAP   = 10;
    localparam int TMO   = 50;
    localparam int RETRY = 2;

    logic       clk_in    = 1'b0;
    logic       rst_in    = 1'b0;
    logic       send_move = 1'b0;
    logic [7:0] move_in   = 8'h00;
    logic       rx_ready  = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       tx_trigger;
    logic [7:0] tx_data;
    logic       move_valid;
    logic [7:0] move_out;
    logic       link_busy;
    logic       link_error;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    int         trig_cyc[$];
    logic [7:0] trig_data[$];
    logic [7:0] valid_data[$];

    move_link #(
        .TX_GAP_CYCLES(GAP),
        .ACK_TIMEOUT  (TMO),
        .MAX_RETRY    (RETRY),
        .ACK_BYTE     (8'hFF)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .send_move (send_move),
        .move_in   (move_in),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .tx_trigger(tx_trigger),
        .tx_data   (tx_data),
        .move_valid(move_valid),
        .move_out  (move_out),
        .link_busy (link_busy),
        .link_error(link_error)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Log every transmitter start and every delivered move, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (tx_trigger === 1'b1) begin
            trig_cyc.push_back(cyc);
            trig_data.push_back(tx_data);
        end
        if (move_valid === 1'b1) begin
            valid_data.push_back(move_out);
        end
    end

    task automatic clear_log;
        trig_cyc.delete();
        trig_data.delete();
        valid_data.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic reset_dut;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        clear_log();
    endtask

    task automatic pulse_send(input logic [7:0] b);
        send_move = 1'b1;
        move_in   = b;
        @(negedge clk_in);
        send_move = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        @(negedge clk_in);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_in = 1'b1;
        #2;
        checks++; if (tx_trigger !== 1'b0) $display("[TB] FAIL reset_tx_trigger: got %b want 0", tx_trigger); else passed++;
        checks++; if (tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
        checks++; if (move_valid !== 1'b0) $display("[TB] FAIL reset_move_valid: got %b want 0", move_valid); else passed++;
        checks++; if (move_out !== 8'h00) $display("[TB] FAIL reset_move_out: got %h want 00", move_out); else passed++;
        checks++; if (link_busy !== 1'b0) $display("[TB] FAIL reset_link_busy: got %b want 0", link_busy); else passed++;
        checks++; if (link_error !== 1'b0) $display("[TB] FAIL reset_link_error: got %b want 0", link_error); else passed++;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        clear_log();
        tick(5);
        checks++; if (trig_data.size() !== 0) $display("[TB] FAIL reset_idle_trigs: got %0d want 0", trig_data.size()); else passed++;
    endtask

    task automatic test_send_ack;
        logic [7:0] got;
        reset_dut();
        pulse_send(8'h34);
        checks++; if (link_busy !== 1'b1) $display("[TB] FAIL send_busy_pending: got %b want 1", link_busy); else passed++;
        tick(18);
        pulse_rx(8'hFF);
        tick(100);
        got = (trig_data.size() > 0) ? trig_data[0] : 8'hxx;
        checks++; if (trig_data.size() !== 1) $display("[TB] FAIL send_trig_count: got %0d want 1", trig_data.size()); else passed++;
        checks++; if (got !== 8'h34) $display("[TB] FAIL send_trig_data: got %h want 34", got); else passed++;
        checks++; if (link_busy !== 1'b0) $display("[TB] FAIL send_busy_after_ack: got %b want 0", link_busy); else passed++;
        checks++; if (link_error !== 1'b0) $display("[TB] FAIL send_error: got %b want 0", link_error); else passed++;
        checks++; if (valid_data.size() !== 0) $display("[TB] FAIL send_no_move_valid: got %0d want 0", valid_data.size()); else passed++;
    endtask

    task automatic test_retry_error;
        int d1;
        int d2;
        reset_dut();
        pulse_send(8'h12);
        tick(260);
        checks++; if (trig_data.size() !== 3) $display("[TB] FAIL retry_trig_count: got %0d want 3", trig_data.size()); else passed++;
        for (int i = 0; i < trig_data.size(); i++) begin
            checks++; if (trig_data[i] !== 8'h12) $display("[TB] FAIL retry_data_%0d: got %h want 12", i, trig_data[i]); else passed++;
        end
        d1 = (trig_cyc.size() >= 2) ? trig_cyc[1] - trig_cyc[0] : -1;
        d2 = (trig_cyc.size() >= 3) ? trig_cyc[2] - trig_cyc[1] : -1;
        checks++; if (d1 !== 60) $display("[TB] FAIL retry_spacing_1: got %0d want 60", d1); else passed++;
        checks++; if (d2 !== 60) $display("[TB] FAIL retry_spacing_2: got %0d want 60", d2); else passed++;
        checks++; if (link_error !== 1'b1) $display("[TB] FAIL retry_link_error: got %b want 1", link_error); else passed++;
        pulse_send(8'h99);
        pulse_rx(8'h40);
        tick(150);
        checks++; if (trig_data.size() !== 3) $display("[TB] FAIL error_no_more_trigs: got %0d want 3", trig_data.size()); else passed++;
        checks++; if (valid_data.size() !== 0) $display("[TB] FAIL error_no_move_valid: got %0d want 0", valid_data.size()); else passed++;
        checks++; if (link_error !== 1'b1) $display("[TB] FAIL error_sticky: got %b want 1", link_error); else passed++;
        checks++; if (link_busy !== 1'b1) $display("[TB] FAIL error_busy: got %b want 1", link_busy); else passed++;
    endtask

    task automatic test_rx_move;
        logic [7:0] got_v;
        logic [7:0] got_t;
        reset_dut();
        pulse_rx(8'h57);
        tick(20);
        got_v = (valid_data.size() > 0) ? valid_data[0] : 8'hxx;
        got_t = (trig_data.size() > 0) ? trig_data[0] : 8'hxx;
        checks++; if (valid_data.size() !== 1) $display("[TB] FAIL rx_valid_count: got %0d want 1", valid_data.size()); else passed++;
        checks++; if (got_v !== 8'h57) $display("[TB] FAIL rx_valid_data: got %h want 57", got_v); else passed++;
        checks++; if (move_out !== 8'h57) $display("[TB] FAIL rx_move_out_held: got %h want 57", move_out); else passed++;
        checks++; if (trig_data.size() !== 1) $display("[TB] FAIL rx_ack_count: got %0d want 1", trig_data.size()); else passed++;
        checks++; if (got_t !== 8'hFF) $display("[TB] FAIL rx_ack_data: got %h want ff", got_t); else passed++;
        checks++; if (link_busy !== 1'b0) $display("[TB] FAIL rx_busy_after: got %b want 0", link_busy); else passed++;
    endtask

    task automatic test_duplicate;
        int exp_valid;
`ifdef MOVE_LINK_DUP_FILTER_EN
        exp_valid = 1;
`else
        exp_valid = 2;
`endif
        reset_dut();
        pulse_rx(8'h57);
        tick(20);
        pulse_rx(8'h57);
        tick(20);
        checks++; if (valid_data.size() !== exp_valid) $display("[TB] FAIL dup_valid_count: got %0d want %0d", valid_data.size(), exp_valid); else passed++;
        checks++; if (trig_data.size() !== 2) $display("[TB] FAIL dup_ack_count: got %0d want 2", trig_data.size()); else passed++;
        for (int i = 0; i < trig_data.size(); i++) begin
            checks++; if (trig_data[i] !== 8'hFF) $display("[TB] FAIL dup_ack_data_%0d: got %h want ff", i, trig_data[i]); else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] t0;
        logic [7:0] t1;
        int         gap_seen;
        reset_dut();
        send_move = 1'b1;
        move_in   = 8'h66;
        rx_ready  = 1'b1;
        rx_data   = 8'h21;
        @(negedge clk_in);
        send_move = 1'b0;
        rx_ready  = 1'b0;
        tick(40);
        t0 = (trig_data.size() > 0) ? trig_data[0] : 8'hxx;
        t1 = (trig_data.size() > 1) ? trig_data[1] : 8'hxx;
        gap_seen = (trig_cyc.size() > 1) ? trig_cyc[1] - trig_cyc[0] : -1;
        checks++; if (trig_data.size() !== 2) $display("[TB] FAIL b2b_trig_count: got %0d want 2", trig_data.size()); else passed++;
        checks++; if (t0 !== 8'hFF) $display("[TB] FAIL b2b_first_is_ack: got %h want ff", t0); else passed++;
        checks++; if (t1 !== 8'h66) $display("[TB] FAIL b2b_second_is_move: got %h want 66", t1); else passed++;
        checks++; if ((gap_seen >= GAP) !== 1'b1) $display("[TB] FAIL b2b_gap: got %0d want >=%0d", gap_seen, GAP); else passed++;
        checks++; if (move_out !== 8'h21) $display("[TB] FAIL b2b_move_out: got %h want 21", move_out); else passed++;
    endtask

    task automatic test_rx_in_wait;
        logic [7:0] t2;
        int         d;
        reset_dut();
        pulse_send(8'h34);
        tick(14);
        pulse_rx(8'h21);
        tick(70);
        t2 = (trig_data.size() > 2) ? trig_data[2] : 8'hxx;
        d  = (trig_cyc.size() > 2) ? trig_cyc[2] - trig_cyc[1] : -1;
        checks++; if (trig_data.size() !== 3) $display("[TB] FAIL wait_trig_count: got %0d want 3", trig_data.size()); else passed++;
        checks++; if (t2 !== 8'h34) $display("[TB] FAIL wait_retx_data: got %h want 34", t2); else passed++;
        checks++; if (d !== 60) $display("[TB] FAIL wait_timeout_restart: got %0d want 60", d); else passed++;
        checks++; if (valid_data.size() !== 1) $display("[TB] FAIL wait_valid_count: got %0d want 1", valid_data.size()); else passed++;
        pulse_rx(8'hFF);
        tick(5);
        checks++; if (link_busy !== 1'b0) $display("[TB] FAIL wait_ack_to_idle: got %b want 0", link_busy); else passed++;
        checks++; if (link_error !== 1'b0) $display("[TB] FAIL wait_no_error: got %b want 0", link_error); else passed++;
    endtask

    task automatic test_reset_mid_wait;
        reset_dut();
        pulse_rx(8'h5A);
        tick(12);
        pulse_send(8'h77);
        tick(20);
        checks++; if (tx_data !== 8'h77) $display("[TB] FAIL midrst_pre_tx_data: got %h want 77", tx_data); else passed++;
        #2 rst_in = 1'b1;
        #1;
        checks++; if (tx_data !== 8'h00) $display("[TB] FAIL midrst_tx_data: got %h want 00", tx_data); else passed++;
        checks++; if (tx_trigger !== 1'b0) $display("[TB] FAIL midrst_tx_trigger: got %b want 0", tx_trigger); else passed++;
        checks++; if (move_valid !== 1'b0) $display("[TB] FAIL midrst_move_valid: got %b want 0", move_valid); else passed++;
        checks++; if (move_out !== 8'h00) $display("[TB] FAIL midrst_move_out: got %h want 00", move_out); else passed++;
        checks++; if (link_busy !== 1'b0) $display("[TB] FAIL midrst_link_busy: got %b want 0", link_busy); else passed++;
        checks++; if (link_error !== 1'b0) $display("[TB] FAIL midrst_link_error: got %b want 0", link_error); else passed++;
        @(negedge clk_in);
        rst_in = 1'b0;
        clear_log();
        tick(150);
        checks++; if (trig_data.size() !== 0) $display("[TB] FAIL midrst_no_trig_after: got %0d want 0", trig_data.size()); else passed++;
        checks++; if (link_busy !== 1'b0) $display("[TB] FAIL midrst_idle_after: got %b want 0", link_busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_send_ack();
        test_retry_error();
        test_rx_move();
        test_duplicate();
        test_back_to_back();
        test_rx_in_wait();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
